// File: rtl/divider_arbiter.sv
// ---------------------------------------------------------------------------
// divider_arbiter
//
// Purpose:
//   Shares one iterative fixed-point divider between two requesters. A
//   round-robin arbiter accepts one request at a time, launches the divider
//   with a one-cycle start pulse, waits for its completion (or a watchdog
//   timeout) and routes the quotient and flags back to the owning requester.
//   A zero divisor is answered directly without starting the divider.
//
// Handshake:
//   A requester raises reqN with aN/bN stable and keeps them until ackN.
//   ackN is a combinational one-cycle pulse in the IDLE cycle where the
//   request is taken; the operands are latched on that clock edge. doneN is
//   a one-cycle registered pulse; qN/dvzN/ovfN/errN are valid with it and
//   hold until the next doneN. A request still (or again) high after doneN
//   is a new request.
//
// Ports:
//   clock, reset            clock (rising edge), async active-high reset
//   req0/a0/b0              requester 0 request, dividend, divisor
//   ack0/done0              requester 0 accept pulse, result pulse
//   q0/dvz0/ovf0/err0       requester 0 quotient and flags (held)
//   req1 ... err1           same for requester 1
//   div_a/div_b/div_start   operands and start pulse to the divider
//   div_busy/div_valid      divider busy and result-valid
//   div_q/div_dvz/div_ovf   divider quotient and flags
//   dbg_state_o             current FSM state (debug)
// ---------------------------------------------------------------------------
module divider_arbiter #(
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  output logic             done0,
  output logic [WIDTH-1:0] q0,
  output logic             dvz0,
  output logic             ovf0,
  output logic             err0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic             done1,
  output logic [WIDTH-1:0] q1,
  output logic             dvz1,
  output logic             ovf1,
  output logic             err1,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic             div_busy,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_q,
  input  logic             div_dvz,
  input  logic             div_ovf,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  // The timeout fires on the last WAIT cycle so that the start cycle, the
  // WAIT cycles and the RESPOND cycle add up to exactly TIMEOUT cycles from
  // the start pulse to the done pulse.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 3);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [7:0]       cnt_q, cnt_d;

  // Result of the operation in flight, written to the owner in RESPOND.
  logic [WIDTH-1:0] rq_q, rq_d;
  logic             rdvz_q, rdvz_d;
  logic             rovf_q, rovf_d;
  logic             rerr_q, rerr_d;

  // Per-requester result registers.
  logic             done0_q, done0_d;
  logic [WIDTH-1:0] q0_q, q0_d;
  logic             dvz0_q, dvz0_d;
  logic             ovf0_q, ovf0_d;
  logic             err0_q, err0_d;
  logic             done1_q, done1_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic             dvz1_q, dvz1_d;
  logic             ovf1_q, ovf1_d;
  logic             err1_q, err1_d;

  // Arbitration.
  logic             elig0, elig1;
  logic             gnt_any;
  logic             gnt_sel;
  logic             do_grant;
  logic [WIDTH-1:0] gnt_a, gnt_b;

  // A port whose done is pulsing this cycle is not granted in the same
  // cycle, so ack and done never coincide on one port; it is taken on the
  // following IDLE cycle.
  always_comb begin
    elig0   = req0 & ~done0_q;
    elig1   = req1 & ~done1_q;
    gnt_any = elig0 | elig1;
    if (elig0 && elig1) begin
      gnt_sel = ~last_grant_q;
    end else begin
      gnt_sel = elig1;
    end
  end

  assign gnt_a    = gnt_sel ? a1 : a0;
  assign gnt_b    = gnt_sel ? b1 : b0;
  assign do_grant = (state_q == ST_IDLE) & gnt_any & ~reset;

  assign ack0      = do_grant & ~gnt_sel;
  assign ack1      = do_grant & gnt_sel;
  assign div_start = (state_q == ST_LAUNCH) & ~div_busy & ~reset;

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rq_d         = rq_q;
    rdvz_d       = rdvz_q;
    rovf_d       = rovf_q;
    rerr_d       = rerr_q;
    done0_d      = 1'b0;
    q0_d         = q0_q;
    dvz0_d       = dvz0_q;
    ovf0_d       = ovf0_q;
    err0_d       = err0_q;
    done1_d      = 1'b0;
    q1_d         = q1_q;
    dvz1_d       = dvz1_q;
    ovf1_d       = ovf1_q;
    err1_d       = err1_q;

    unique case (state_q)
      ST_IDLE: begin
        if (do_grant) begin
          owner_d      = gnt_sel;
          last_grant_d = gnt_sel;
          a_d          = gnt_a;
          b_d          = gnt_b;
          if (gnt_b == '0) begin
            rq_d    = '0;
            rdvz_d  = 1'b1;
            rovf_d  = 1'b0;
            rerr_d  = 1'b0;
            state_d = ST_RESPOND;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end

      ST_LAUNCH: begin
        if (!div_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (div_valid) begin
          rq_d    = div_q;
          rdvz_d  = div_dvz;
          rovf_d  = div_ovf;
          rerr_d  = 1'b0;
          state_d = ST_RESPOND;
        end else if (cnt_q == TO_LAST) begin
          rq_d    = '0;
          rdvz_d  = 1'b0;
          rovf_d  = 1'b0;
          rerr_d  = 1'b1;
          state_d = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        if (owner_q == 1'b0) begin
          q0_d    = rq_q;
          dvz0_d  = rdvz_q;
          ovf0_d  = rovf_q;
          err0_d  = rerr_q;
          done0_d = 1'b1;
        end else begin
          q1_d    = rq_q;
          dvz1_d  = rdvz_q;
          ovf1_d  = rovf_q;
          err1_d  = rerr_q;
          done1_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rq_q         <= '0;
      rdvz_q       <= 1'b0;
      rovf_q       <= 1'b0;
      rerr_q       <= 1'b0;
      done0_q      <= 1'b0;
      q0_q         <= '0;
      dvz0_q       <= 1'b0;
      ovf0_q       <= 1'b0;
      err0_q       <= 1'b0;
      done1_q      <= 1'b0;
      q1_q         <= '0;
      dvz1_q       <= 1'b0;
      ovf1_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rq_q         <= rq_d;
      rdvz_q       <= rdvz_d;
      rovf_q       <= rovf_d;
      rerr_q       <= rerr_d;
      done0_q      <= done0_d;
      q0_q         <= q0_d;
      dvz0_q       <= dvz0_d;
      ovf0_q       <= ovf0_d;
      err0_q       <= err0_d;
      done1_q      <= done1_d;
      q1_q         <= q1_d;
      dvz1_q       <= dvz1_d;
      ovf1_q       <= ovf1_d;
      err1_q       <= err1_d;
    end
  end

  assign done0       = done0_q;
  assign q0          = q0_q;
  assign dvz0        = dvz0_q;
  assign ovf0        = ovf0_q;
  assign err0        = err0_q;
  assign done1       = done1_q;
  assign q1          = q1_q;
  assign dvz1        = dvz1_q;
  assign ovf1        = ovf1_q;
  assign err1        = err1_q;
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// ---------------------------------------------------------------------------
// tb_divider_arbiter
//
// Self-checking bench for divider_arbiter. A behavioural divider model
// (Q.8 fixed-point quotient, programmable latency, hang and busy hold-off
// modes) sits on the divider side. Drivers push the expected per-port result
// into a queue when a request is issued; a monitor pops and compares on every
// done pulse. Directed tests cover latencies, fairness, zero divisor,
// timeout, busy hold-off and reset mid-operation; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_divider_arbiter;

  localparam int W  = 10;
  localparam int TO = 255;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT
  // -------------------------------------------------------------------------
  logic         clock = 1'b0;
  logic         reset;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, done0, dvz0, ovf0, err0;
  logic         ack1, done1, dvz1, ovf1, err1;
  logic [W-1:0] q0, q1, div_a, div_b;
  logic         div_start;
  logic         div_busy, div_valid, div_dvz, div_ovf;
  logic [W-1:0] div_q;
  logic [1:0]   dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  divider_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .done0(done0),
    .q0(q0), .dvz0(dvz0), .ovf0(ovf0), .err0(err0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .done1(done1),
    .q1(q1), .dvz1(dvz1), .ovf1(ovf1), .err1(err1),
    .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_busy(div_busy), .div_valid(div_valid), .div_q(div_q),
    .div_dvz(div_dvz), .div_ovf(div_ovf), .dbg_state_o(dbg_state)
  );

  // -------------------------------------------------------------------------
  // Counters and check helper
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference: Q.8 fixed-point divide, saturating to all-ones with overflow
  // -------------------------------------------------------------------------
  function automatic logic [W:0] fx_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int full;
    full = (32'(a) * 256) / 32'(b);
    if (full > 1023) return {10'h3FF, 1'b1};
    return {full[9:0], 1'b0};
  endfunction

  // Expected {q, dvz, ovf, err} for one accepted request.
  function automatic logic [W+2:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input bit hang_mode);
    logic [W:0] r;
    if (b == '0) return {10'd0, 3'b100};
    if (hang_mode) return {10'd0, 3'b001};
    r = fx_div(a, b);
    return {r[W:1], 1'b0, r[0], 1'b0};
  endfunction

  // -------------------------------------------------------------------------
  // Divider model
  // -------------------------------------------------------------------------
  bit           hang       = 1'b0;
  int           lat_lo     = 66;
  int           lat_hi     = 66;
  int           busy_until = 0;
  int           start_count = 0;
  int           start_cyc  = -1;
  logic [W-1:0] start_a, start_b;

  initial begin
    bit           st;
    bit           prev_st = 1'b0;
    bit           active  = 1'b0;
    int           due     = 0;
    logic [W-1:0] la = '0, lb = '0;
    div_busy  = 1'b0;
    div_valid = 1'b0;
    div_q     = '0;
    div_dvz   = 1'b0;
    div_ovf   = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      st = div_start;
      if (st) begin
        start_count++;
        start_cyc = cyc;
        start_a   = div_a;
        start_b   = div_b;
        la        = div_a;
        lb        = div_b;
        check("start_single_cycle", 64'(prev_st), 64'd0);
      end
      prev_st = st;
      @(posedge clock);
      #1;
      if (reset) begin
        active    = 1'b0;
        div_busy  = 1'b0;
        div_valid = 1'b0;
        continue;
      end
      if (st) begin
        active = !hang;
        due    = start_cyc + $urandom_range(lat_hi, lat_lo);
      end
      div_valid = 1'b0;
      if (active && cyc == due) begin
        {div_q, div_ovf} = fx_div(la, lb);
        div_dvz   = 1'b0;
        div_valid = 1'b1;
        active    = 1'b0;
      end
      div_busy = active || (cyc < busy_until);
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard and monitor
  // -------------------------------------------------------------------------
  logic [W+2:0] exp_q0[$];
  logic [W+2:0] exp_q1[$];
  int           grant_log[$];
  int           ack_cyc[2]   = '{default: 0};
  int           done_cyc[2]  = '{default: 0};
  int           done_cnt[2]  = '{default: 0};
  int           raise_cyc[2] = '{default: 0};
  int           valid_cyc    = 0;

  initial forever begin
    logic [W+2:0] e;
    @(negedge clock);
    #2;
    if (!reset) begin
      if (ack0 || ack1 || done0 || done1)
        check("handshake_exclusive",
              64'((ack0 & ack1) | (done0 & done1) | (ack0 & done0) | (ack1 & done1)), 64'd0);
      if (ack0) begin grant_log.push_back(0); ack_cyc[0] = cyc; end
      if (ack1) begin grant_log.push_back(1); ack_cyc[1] = cyc; end
      if (div_valid) valid_cyc = cyc;
      if (done0) begin
        check("done0_expected", 64'(exp_q0.size() > 0), 64'd1);
        if (exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          check("result_p0", 64'({q0, dvz0, ovf0, err0}), 64'(e));
        end
        done_cyc[0] = cyc;
        done_cnt[0]++;
      end
      if (done1) begin
        check("done1_expected", 64'(exp_q1.size() > 0), 64'd1);
        if (exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          check("result_p1", 64'({q1, dvz1, ovf1, err1}), 64'(e));
        end
        done_cyc[1] = cyc;
        done_cnt[1]++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 1'b0;
    if (p == 0) exp_q0.push_back(ref_result(a, b, hang));
    else        exp_q1.push_back(ref_result(a, b, hang));
    @(negedge clock);
    if (p == 0) begin req0 = 1'b1; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; a1 = a; b1 = b; end
    raise_cyc[p] = cyc;
    for (int k = 0; k < 3000 && !got; k++) begin
      #1;
      got = (p == 0) ? ack0 : ack1;
      if (!got) @(negedge clock);
    end
    check($sformatf("ack_seen_p%0d", p), 64'(got), 64'd1);
    if (got) @(posedge clock);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic wait_done(input int p, input int n0, input int budget);
    int k = 0;
    while (done_cnt[p] <= n0 && k < budget) begin
      @(negedge clock);
      #3;
      k++;
    end
    check($sformatf("done_arrived_p%0d", p), 64'(done_cnt[p] > n0), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #3;
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({ack0, done0, q0, dvz0, ovf0, err0, ack1, done1, q1, dvz1, ovf1, err1,
                div_a, div_b, div_start});
  endfunction

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    int s0, n0, n1, g, first_done0, k, bu;
    logic [W-1:0] ca1, cb1;

    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;

    // Single request through the divider.
    s0 = start_count; n0 = done_cnt[0];
    issue(0, 10'h0A0, 10'h0B0);
    check("single_ack_latency", 64'(ack_cyc[0] - raise_cyc[0]), 64'd0);
    wait_done(0, n0, 300);
    check("single_start_count", 64'(start_count - s0), 64'd1);
    check("single_div_a", 64'(start_a), 64'h0A0);
    check("single_div_b", 64'(start_b), 64'h0B0);
    check("single_ack_to_start", 64'(start_cyc - ack_cyc[0]), 64'd1);
    check("single_valid_to_done", 64'(done_cyc[0] - valid_cyc), 64'd2);
    check("single_q0", 64'(q0), 64'h0E8);
    check("single_flags0", 64'({dvz0, ovf0, err0}), 64'd0);

    // Contention from reset: grant order 0,1,0.
    do_reset();
    lat_lo = 10; lat_hi = 10;
    g = grant_log.size(); n0 = done_cnt[0]; n1 = done_cnt[1];
    first_done0 = 0;
    ca1 = 10'h050; cb1 = 10'h0C8;
    fork
      begin
        issue(0, 10'h100, 10'h080);
        wait_done(0, n0, 200);
        first_done0 = done_cyc[0];
        issue(0, 10'h033, 10'h1F0);
      end
      issue(1, ca1, cb1);
    join
    wait_done(0, n0 + 1, 300);
    wait_done(1, n1, 300);
    check("contention_grant_count", 64'(grant_log.size() >= g + 3), 64'd1);
    if (grant_log.size() >= g + 3) begin
      check("contention_grant_0", 64'(grant_log[g]),     64'd0);
      check("contention_grant_1", 64'(grant_log[g + 1]), 64'd1);
      check("contention_grant_2", 64'(grant_log[g + 2]), 64'd0);
    end
    check("ack1_not_before_done0", 64'(ack_cyc[1] >= first_done0), 64'd1);
    check("q1_held", 64'({q1, dvz1, ovf1, err1}), 64'(ref_result(ca1, cb1, 1'b0)));
    check("q0_own", 64'({q0, dvz0, ovf0, err0}), 64'(ref_result(10'h033, 10'h1F0, 1'b0)));

    // Divide by zero short-circuit.
    s0 = start_count; n1 = done_cnt[1];
    issue(1, 10'h2AB, 10'h000);
    wait_done(1, n1, 50);
    check("dvz_ack_to_done", 64'(done_cyc[1] - ack_cyc[1]), 64'd2);
    check("dvz_no_start", 64'(start_count - s0), 64'd0);
    check("dvz_q1", 64'(q1), 64'd0);
    check("dvz_flag1", 64'(dvz1), 64'd1);

    // Watchdog timeout.
    hang = 1'b1;
    n0 = done_cnt[0];
    issue(0, 10'h123, 10'h045);
    wait_done(0, n0, 400);
    check("timeout_start_to_done", 64'(done_cyc[0] - start_cyc), 64'(TO));
    check("timeout_err0", 64'(err0), 64'd1);
    check("timeout_q0", 64'(q0), 64'd0);
    hang = 1'b0;

    // Busy hold-off: divider busy at grant and for 5 more cycles.
    lat_lo = 5; lat_hi = 5;
    s0 = start_count; n0 = done_cnt[0];
    @(negedge clock);
    bu = cyc + 7;
    busy_until = bu;
    issue(0, 10'h1C0, 10'h0E0);
    wait_done(0, n0, 100);
    check("busy_start_cycle", 64'(start_cyc), 64'(bu));
    check("busy_ack_to_start", 64'(start_cyc - ack_cyc[0]), 64'd6);
    check("busy_start_count", 64'(start_count - s0), 64'd1);

    // Reset while waiting on the divider.
    lat_lo = 200; lat_hi = 200;
    s0 = start_count;
    issue(0, 10'h0F0, 10'h011);
    k = 0;
    while (start_count == s0 && k < 50) begin @(negedge clock); #3; k++; end
    check("reset_test_started", 64'(start_count - s0), 64'd1);
    repeat (20) @(negedge clock);
    #3 reset = 1'b1;
    #1;
    check("async_reset_outputs", all_outputs(), 64'd0);
    exp_q0.delete();
    n0 = done_cnt[0];
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("no_done_after_reset", 64'(done_cnt[0] - n0), 64'd0);
    lat_lo = 1; lat_hi = 20;
    g = grant_log.size(); n0 = done_cnt[0]; n1 = done_cnt[1];
    fork
      issue(0, 10'h200, 10'h100);
      issue(1, 10'h010, 10'h020);
    join
    wait_done(0, n0, 200);
    wait_done(1, n1, 200);
    check("post_reset_first_grant", 64'(grant_log.size() > g ? grant_log[g] : 9), 64'd0);

    // Randomized traffic on both ports.
    fork
      for (int i = 0; i < 25; i++) begin
        int n;
        logic [W-1:0] ra, rb;
        ra = W'($urandom);
        rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 1023));
        n  = done_cnt[0];
        issue(0, ra, rb);
        wait_done(0, n, 400);
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      for (int j = 0; j < 25; j++) begin
        int n;
        logic [W-1:0] ra, rb;
        ra = W'($urandom);
        rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 1023));
        n  = done_cnt[1];
        issue(1, ra, rb);
        wait_done(1, n, 400);
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
    join

    repeat (5) @(negedge clock);
    check("exp_q0_drained", 64'(exp_q0.size()), 64'd0);
    check("exp_q1_drained", 64'(exp_q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
